// File: rtl/enc_pend_n_reg_if.sv
// Request/grant bundle for enc_pend_n_reg.
// The master side drives requests, enable and ready. The slave side (the encoder) returns
// the granted index, its valid flag and the pending status.
interface enc_pend_n_reg_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned W = $clog2(N);

  logic         en;
  logic [N-1:0] req;
  logic [W-1:0] y_idx;
  logic         y_valid;
  logic         y_ready;
  logic [N-1:0] pending;

  modport master (
    output en, req, y_ready,
    input  y_idx, y_valid, pending
  );

  modport slave (
    input  en, req, y_ready,
    output y_idx, y_valid, pending
  );
endinterface

// File: rtl/enc_pend_n_reg.sv
// Registered N:log2(N) priority encoder with a sticky pending register.
// Request bits collect into pend. One encoded index is issued at a time over a
// valid/ready handshake, and each served bit is cleared.
// Optional macro ROUND_ROBIN_EN: when defined, selection rotates from a pointer.
// Otherwise the lowest set index wins (fixed priority).
module enc_pend_n_reg #(
  parameter int unsigned N = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  enc_pend_n_reg_if.slave   bus
);
  localparam int unsigned W = $clog2(N);

  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] y_idx_q, y_idx_d;
  logic         y_valid_q, y_valid_d;
  logic [N-1:0] clr;
  logic [W-1:0] sel;
  logic         load;

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx;
  logic         found;

  // Round robin: the first set bit at or after ptr, wrapping modulo N.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + W'(k);
      if (!found && pend_q[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: the lowest set index wins. The descending scan leaves the lowest one in sel.
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel = W'(i);
      end
    end
  end
`endif

  // Load step and next-state for the pending register.
  // Selection always works on the registered pend, never on raw req.
  always_comb begin
    load      = !y_valid_q || bus.y_ready;
    clr       = '0;
    y_idx_d   = y_idx_q;
    y_valid_d = y_valid_q;
`ifdef ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    if (load) begin
      if (pend_q != '0) begin
        y_idx_d   = sel;
        y_valid_d = 1'b1;
        clr[sel]  = 1'b1;
`ifdef ROUND_ROBIN_EN
        ptr_d     = sel + W'(1);
`endif
      end else begin
        // Nothing to issue. y_idx keeps its last value.
        y_valid_d = 1'b0;
      end
    end
    // The set term is ORed in last, so a request that arrives on the same edge
    // its old copy is cleared stays pending.
    pend_d = (pend_q & ~clr) | (bus.en ? bus.req : '0);
  end

  // State registers. The synchronous reset overrides every other update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q    <= '0;
      y_idx_q   <= '0;
      y_valid_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      pend_q    <= pend_d;
      y_idx_q   <= y_idx_d;
      y_valid_q <= y_valid_d;
`ifdef ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.y_idx   = y_idx_q;
  assign bus.y_valid = y_valid_q;
  assign bus.pending = pend_q;

endmodule

// File: tb/tb_enc_pend_n_reg.sv
// Self-checking bench for enc_pend_n_reg (N=4). Expected grant indices are queued
// when stimulus is applied and popped when the DUT presents an accepted grant.
module tb_enc_pend_n_reg;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [1:0] exp_q[$];
  logic [1:0] e;

  always #5 clk = ~clk;

  enc_pend_n_reg_if #(.N(4)) bus ();

  enc_pend_n_reg #(.N(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.en = 1'b0; bus.req = 4'b0000; bus.y_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b1; bus.req = 4'b1111; bus.y_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.y_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_valid got=%b want=0", bus.y_valid); end
    n_cmp++; if (bus.y_idx !== 2'd0) begin n_bad++;
      $display("FAIL reset_idx got=%0d want=0", bus.y_idx); end
    n_cmp++; if (bus.pending !== 4'b0000) begin n_bad++;
      $display("FAIL reset_pending got=%b want=0000", bus.pending); end
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.pending !== 4'b1111) begin n_bad++;
      $display("FAIL reset_release_pending got=%b want=1111", bus.pending); end
    n_cmp++; if (bus.y_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_release_valid got=%b want=0", bus.y_valid); end
  endtask

  // Hold a grant under backpressure, then reset: both the grant and pend must drop.
  task automatic test_reset_drop();
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0110; bus.y_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.y_valid !== 1'b1 || bus.y_idx !== 2'd1) begin n_bad++;
      $display("FAIL drop_pre got=%b/%0d want=1/1", bus.y_valid, bus.y_idx); end
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.y_valid !== 1'b0 || bus.pending !== 4'b0000) begin n_bad++;
      $display("FAIL drop_post got=%b/%b want=0/0000", bus.y_valid, bus.pending); end
    rst = 1'b0; bus.req = 4'b0000; bus.en = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0100; bus.y_ready = 1'b1;
    exp_q.push_back(2'd2);
    tick();
    bus.req = 4'b0000;
    n_cmp++; if (bus.y_valid !== 1'b0) begin n_bad++;
      $display("FAIL single_early got=%b want=0", bus.y_valid); end
    tick();
    n_cmp++; if (bus.y_valid !== 1'b1) begin n_bad++;
      $display("FAIL single_valid got=%b want=1", bus.y_valid); end
    else if (exp_q.size() == 0) begin n_bad++;
      $display("FAIL single_sb got=grant want=none"); end
    else begin
      e = exp_q.pop_front();
      if (bus.y_idx !== e) begin n_bad++;
        $display("FAIL single_idx got=%0d want=%0d", bus.y_idx, e); end
    end
    tick();
    n_cmp++; if (bus.y_valid !== 1'b0 || bus.pending !== 4'b0000) begin n_bad++;
      $display("FAIL single_after got=%b/%b want=0/0000", bus.y_valid, bus.pending); end
  endtask

  task automatic test_drain();
    do_reset();
    bus.en = 1'b1; bus.req = 4'b1011; bus.y_ready = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    tick();
    bus.req = 4'b0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.y_valid !== 1'b1) begin n_bad++;
        $display("FAIL drain_valid[%0d] got=%b want=1", i, bus.y_valid); end
      else if (exp_q.size() == 0) begin n_bad++;
        $display("FAIL drain_sb[%0d] got=grant want=none", i); end
      else begin
        e = exp_q.pop_front();
        if (bus.y_idx !== e) begin n_bad++;
          $display("FAIL drain_idx[%0d] got=%0d want=%0d", i, bus.y_idx, e); end
      end
      tick();
    end
    n_cmp++; if (bus.y_valid !== 1'b0 || bus.pending !== 4'b0000) begin n_bad++;
      $display("FAIL drain_end got=%b/%b want=0/0000", bus.y_valid, bus.pending); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0010; bus.y_ready = 1'b0;
    exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    tick();
    bus.req = 4'b0000;
    tick();
    for (int c = 0; c < 5; c++) begin
      bus.req = (c == 0) ? 4'b1000 : 4'b0000;
      tick();
      n_cmp++; if (bus.y_valid !== 1'b1 || bus.y_idx !== 2'd1) begin n_bad++;
        $display("FAIL bp_hold[%0d] got=%b/%0d want=1/1", c, bus.y_valid, bus.y_idx); end
    end
    n_cmp++; if (bus.pending !== 4'b1000) begin n_bad++;
      $display("FAIL bp_pending got=%b want=1000", bus.pending); end
    bus.y_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (bus.y_valid !== 1'b1) begin n_bad++;
        $display("FAIL bp_valid[%0d] got=%b want=1", i, bus.y_valid); end
      else if (exp_q.size() == 0) begin n_bad++;
        $display("FAIL bp_sb[%0d] got=grant want=none", i); end
      else begin
        e = exp_q.pop_front();
        if (bus.y_idx !== e) begin n_bad++;
          $display("FAIL bp_idx[%0d] got=%0d want=%0d", i, bus.y_idx, e); end
      end
      tick();
    end
    n_cmp++; if (bus.y_valid !== 1'b0 || exp_q.size() != 0) begin n_bad++;
      $display("FAIL bp_end got=%b/%0d want=0/0", bus.y_valid, exp_q.size()); end
  endtask

  task automatic test_enable_off();
    do_reset();
    bus.en = 1'b0; bus.req = 4'b1111; bus.y_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (bus.pending !== 4'b0000 || bus.y_valid !== 1'b0) begin n_bad++;
        $display("FAIL en_off[%0d] got=%b/%b want=0000/0", c, bus.pending, bus.y_valid); end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_fairness();
    do_reset();
    bus.en = 1'b1; bus.req = 4'b1001; bus.y_ready = 1'b1;
`ifdef ROUND_ROBIN_EN
    exp_q.push_back(2'd0); exp_q.push_back(2'd3); exp_q.push_back(2'd0); exp_q.push_back(2'd3);
`else
    exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0);
`endif
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.y_valid !== 1'b1) begin n_bad++;
        $display("FAIL fair_valid[%0d] got=%b want=1", i, bus.y_valid); end
      else if (exp_q.size() == 0) begin n_bad++;
        $display("FAIL fair_sb[%0d] got=grant want=none", i); end
      else begin
        e = exp_q.pop_front();
        if (bus.y_idx !== e) begin n_bad++;
          $display("FAIL fair_idx[%0d] got=%0d want=%0d", i, bus.y_idx, e); end
      end
      n_cmp++; if (bus.pending !== 4'b1001) begin n_bad++;
        $display("FAIL fair_pending[%0d] got=%b want=1001", i, bus.pending); end
      tick();
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.req = 4'b0000; bus.y_ready = 1'b0;
    test_reset();
    test_reset_drop();
    test_single();
    test_drain();
    test_backpressure();
    test_enable_off();
    test_fairness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
